// File: rtl/gate_stim_sequencer.sv
// Programmable stimulus sequencer for the gate stage: plays a table of
// 4-bit a/b/c/d patterns, each held for its own dwell count, once or looping.
module gate_stim_sequencer #(
  parameter int NUM_VEC = 16,
  parameter int IDX_W   = 4,
  parameter int DWELL_W = 8,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_addr,
  input  logic [3:0]         wr_pattern,
  input  logic [DWELL_W-1:0] wr_dwell,
  input  logic               start,
  input  logic               abort,
  input  logic               loop_en,
  input  logic [IDX_W-1:0]   last_idx,
  output logic               a,
  output logic               b,
  output logic               c,
  output logic               d,
  output logic               vec_valid,
  output logic [IDX_W-1:0]   vec_idx,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   pass_count
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t               r_state, w_state_next;
  logic [3:0]           r_pat, w_pat_next;
  logic                 r_valid, w_valid_next;
  logic [IDX_W-1:0]     r_idx, w_idx_next;
  logic                 r_busy, w_busy_next;
  logic                 r_done, w_done_next;
  logic [CNT_W-1:0]     r_pass, w_pass_next;
  logic [DWELL_W-1:0]   r_cnt, w_cnt_next;
  logic                 r_loop, w_loop_next;
  logic [IDX_W-1:0]     r_last, w_last_next;

  // Pattern table; kept in flops because reset must clear every entry.
  logic [3:0]           r_tab_pat   [NUM_VEC];
  logic [DWELL_W-1:0]   r_tab_dwell [NUM_VEC];

  logic [IDX_W-1:0]     w_idx_inc;
  logic [DWELL_W-1:0]   w_load0;
  logic [DWELL_W-1:0]   w_load_inc;
  logic                 w_wr_ok;

  // Dwell of 0 behaves like 1, so the counter preload is max(dwell,1)-1.
  function automatic logic [DWELL_W-1:0] dwell_load(input logic [DWELL_W-1:0] dw);
    dwell_load = (dw == '0) ? '0 : dw - DWELL_W'(1);
  endfunction

  assign w_idx_inc  = r_idx + IDX_W'(1);
  assign w_load0    = dwell_load(r_tab_dwell[0]);
  assign w_load_inc = dwell_load(r_tab_dwell[w_idx_inc]);
  // Table is frozen while a run is in progress.
  assign w_wr_ok    = wr_en && (r_state == S_IDLE);

  // Table write port, only active in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_VEC; i++) begin
        r_tab_pat[i]   <= '0;
        r_tab_dwell[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_tab_pat[wr_addr]   <= wr_pattern;
      r_tab_dwell[wr_addr] <= wr_dwell;
    end
  end

  // State and registered-output update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pat   <= '0;
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= '0;
      r_cnt   <= '0;
      r_loop  <= 1'b0;
      r_last  <= '0;
    end else begin
      r_state <= w_state_next;
      r_pat   <= w_pat_next;
      r_valid <= w_valid_next;
      r_idx   <= w_idx_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
      r_pass  <= w_pass_next;
      r_cnt   <= w_cnt_next;
      r_loop  <= w_loop_next;
      r_last  <= w_last_next;
    end
  end

  // Next-state logic: start/abort handling and entry sequencing.
  always_comb begin
    w_state_next = r_state;
    w_pat_next   = r_pat;
    w_valid_next = r_valid;
    w_idx_next   = r_idx;
    w_busy_next  = r_busy;
    w_done_next  = 1'b0;
    w_pass_next  = r_pass;
    w_cnt_next   = r_cnt;
    w_loop_next  = r_loop;
    w_last_next  = r_last;

    case (r_state)
      S_IDLE: begin
        w_pat_next   = '0;
        w_valid_next = 1'b0;
        w_busy_next  = 1'b0;
        if (start && !abort) begin
          w_state_next = S_RUN;
          w_idx_next   = '0;
          w_pat_next   = r_tab_pat[0];
          w_valid_next = 1'b1;
          w_busy_next  = 1'b1;
          w_pass_next  = '0;
          w_loop_next  = loop_en;
          w_last_next  = last_idx;
          w_cnt_next   = w_load0;
        end
      end
      S_RUN: begin
        if (abort) begin
          w_state_next = S_IDLE;
          w_pat_next   = '0;
          w_valid_next = 1'b0;
          w_busy_next  = 1'b0;
        end else if (r_cnt != '0) begin
          w_cnt_next = r_cnt - DWELL_W'(1);
        end else if (r_idx != r_last) begin
          // Advance to the next entry with no gap cycle.
          w_idx_next = w_idx_inc;
          w_pat_next = r_tab_pat[w_idx_inc];
          w_cnt_next = w_load_inc;
        end else if (r_loop) begin
          w_idx_next  = '0;
          w_pat_next  = r_tab_pat[0];
          w_cnt_next  = w_load0;
          w_pass_next = r_pass + CNT_W'(1);
        end else begin
          w_pass_next  = r_pass + CNT_W'(1);
          w_state_next = S_IDLE;
          w_pat_next   = '0;
          w_valid_next = 1'b0;
          w_busy_next  = 1'b0;
          w_done_next  = 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign a          = r_pat[3];
  assign b          = r_pat[2];
  assign c          = r_pat[1];
  assign d          = r_pat[0];
  assign vec_valid  = r_valid;
  assign vec_idx    = r_idx;
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass_count = r_pass;

endmodule

// File: tb/tb_gate_stim_sequencer.sv
// Directed bench for gate_stim_sequencer: table-driven single-pass sequence
// plus hand-written looping, abort, mid-run write/start and reset sequences.
module tb_gate_stim_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [3:0] wr_pattern;
  logic [7:0] wr_dwell;
  logic       start;
  logic       abort;
  logic       loop_en;
  logic [3:0] last_idx;
  logic       a, b, c, d;
  logic       vec_valid;
  logic [3:0] vec_idx;
  logic       busy;
  logic       done;
  logic [7:0] pass_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] pat;
    logic       valid;
    logic       busy;
    logic       done;
    logic [3:0] idx;
    logic [7:0] pass;
  } exp_t;

  exp_t exp_tab [12];
  logic [18:0] w_act;

  assign w_act = {a, b, c, d, vec_valid, busy, done, vec_idx, pass_count};

  gate_stim_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_pattern (wr_pattern),
    .wr_dwell   (wr_dwell),
    .start      (start),
    .abort      (abort),
    .loop_en    (loop_en),
    .last_idx   (last_idx),
    .a          (a),
    .b          (b),
    .c          (c),
    .d          (d),
    .vec_valid  (vec_valid),
    .vec_idx    (vec_idx),
    .busy       (busy),
    .done       (done),
    .pass_count (pass_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end else begin
      $display("ok   %s value=%h", name, act);
    end
  endtask

  task automatic write_entry(input logic [3:0] addr, input logic [3:0] pat, input logic [7:0] dw);
    wr_en = 1'b1; wr_addr = addr; wr_pattern = pat; wr_dwell = dw;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Plays entries 0..4 once and compares every cycle against exp_tab.
  // With inject set, a table write and a looping start are attempted mid-run.
  task automatic run_seq(input bit inject, input string tag);
    last_idx = 4'd4; loop_en = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      check($sformatf("%s_c%0d", tag, i), 32'(w_act), 32'(exp_tab[i]));
      if (inject && i == 1) begin
        wr_en = 1'b1; wr_addr = 4'd1; wr_pattern = 4'hF; wr_dwell = 8'd7;
        start = 1'b1; loop_en = 1'b1; last_idx = 4'd0;
      end
      @(negedge clk);
      wr_en = 1'b0; start = 1'b0; loop_en = 1'b0;
    end
  endtask

  initial begin
    exp_t e;
    // Expected single pass of {1010,1},{0101,2},{0010,1},{1111,1},{0000,5}.
    exp_tab[0]  = '{4'b1010, 1'b1, 1'b1, 1'b0, 4'd0, 8'd0};
    exp_tab[1]  = '{4'b0101, 1'b1, 1'b1, 1'b0, 4'd1, 8'd0};
    exp_tab[2]  = '{4'b0101, 1'b1, 1'b1, 1'b0, 4'd1, 8'd0};
    exp_tab[3]  = '{4'b0010, 1'b1, 1'b1, 1'b0, 4'd2, 8'd0};
    exp_tab[4]  = '{4'b1111, 1'b1, 1'b1, 1'b0, 4'd3, 8'd0};
    for (int i = 5; i < 10; i++)
      exp_tab[i] = '{4'b0000, 1'b1, 1'b1, 1'b0, 4'd4, 8'd0};
    exp_tab[10] = '{4'b0000, 1'b0, 1'b0, 1'b1, 4'd4, 8'd1};
    exp_tab[11] = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'd4, 8'd1};

    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_pattern = '0; wr_dwell = '0;
    start = 1'b0; abort = 1'b0; loop_en = 1'b0; last_idx = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_state", 32'(w_act), 32'd0);

    // Single pass.
    write_entry(4'd0, 4'b1010, 8'd1);
    write_entry(4'd1, 4'b0101, 8'd2);
    write_entry(4'd2, 4'b0010, 8'd1);
    write_entry(4'd3, 4'b1111, 8'd1);
    write_entry(4'd4, 4'b0000, 8'd5);
    run_seq(1'b0, "pass1");

    // Dwell 0 behaves as 1, last_idx 0 plays entry 0 only.
    write_entry(4'd0, 4'b1010, 8'd0);
    last_idx = 4'd0; loop_en = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("dw0_c0", 32'(w_act), 32'({4'b1010, 1'b1, 1'b1, 1'b0, 4'd0, 8'd0}));
    @(negedge clk);
    check("dw0_c1", 32'(w_act), 32'({4'b0000, 1'b0, 1'b0, 1'b1, 4'd0, 8'd1}));
    write_entry(4'd0, 4'b1010, 8'd1);

    // Looping run for 25 cycles, then abort.
    last_idx = 4'd4; loop_en = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; loop_en = 1'b0;
    for (int i = 0; i < 25; i++) begin
      e = exp_tab[i % 10];
      e.pass = 8'(i / 10);
      check($sformatf("loop_c%0d", i), 32'(w_act), 32'(e));
      if (i == 24) abort = 1'b1;
      @(negedge clk);
    end
    abort = 1'b0;
    check("abort_out", 32'({a, b, c, d, vec_valid, busy, done, pass_count}), 32'({4'b0, 3'b000, 8'd2}));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("abort_nodone%0d", i), 32'({done, busy, pass_count}), 32'({1'b0, 1'b0, 8'd2}));
    end

    // Mid-run write and looping start are ignored; entry 1 stays intact.
    run_seq(1'b1, "inject");
    run_seq(1'b0, "after_inject");

    // start and abort together in IDLE.
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle", 32'({busy, vec_valid}), 32'd0);
    @(negedge clk);
    check("start_abort_idle2", 32'({busy, vec_valid}), 32'd0);

    // Reset mid-run at entry 2.
    last_idx = 4'd4; loop_en = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_idx", 32'(vec_idx), 32'd2);
    rst_n = 1'b0;
    #1;
    check("async_rst", 32'(w_act), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    last_idx = 4'd4; loop_en = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("cleared_c0", 32'(w_act), 32'({4'b0000, 1'b1, 1'b1, 1'b0, 4'd0, 8'd0}));
    @(negedge clk);
    check("cleared_c1", 32'(w_act), 32'({4'b0000, 1'b1, 1'b1, 1'b0, 4'd1, 8'd0}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
